// File: rtl/recepcao_medida_uc_fd.sv
// Receive end of the measurement serial link: UART 8N1 receiver, frame parser and
// BCD-to-binary conversion that rebuild the temperature and humidity words.
module recepcao_medida_uc_fd #(
  parameter int         CLKS_PER_BIT = 5208,
  parameter logic [7:0] TERMINADOR   = 8'h23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_serial,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic        pronto,
  output logic        erro,
  output logic [2:0]  db_estado
);

  localparam int              CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   FIM_BIT     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   FIM_MEIO    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int              OCIO_CICLOS = 10 * CLKS_PER_BIT;
  localparam int              AW          = $clog2(OCIO_CICLOS + 1);
  localparam logic [AW-1:0]   OCIO_FIM    = AW'(OCIO_CICLOS - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DADOS, U_STOP} uart_estado_t;
  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    DIGITO   = 3'd1,
    FINAL    = 3'd2,
    CONVERTE = 3'd3,
    PUBLICA  = 3'd4
  } quadro_estado_t;

  function automatic logic [6:0] bcd_bin(input logic [3:0] dezena, input logic [3:0] unidade);
    return 7'(dezena) * 7'd10 + 7'(unidade);
  endfunction

  // ---------------- input synchronizer and line-idle qualification ----------------
  logic            rx_meta, rx_sync, rx_ant;
  logic            linha_ok;
  logic [AW-1:0]   ocio_cnt;
  logic            borda;

  // A start edge only counts once the line has been seen idle for a whole
  // character time, so a byte cut in half by reset is never half-received.
  // NOTE: sequential state is always assigned with <= so every flop samples the pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_ant   <= 1'b1;
      linha_ok <= 1'b0;
      ocio_cnt <= '0;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      rx_ant  <= rx_sync;
      if (!linha_ok) begin
        if (!rx_sync)                  ocio_cnt <= '0;
        else if (ocio_cnt == OCIO_FIM) linha_ok <= 1'b1;
        else                           ocio_cnt <= ocio_cnt + 1'b1;
      end
    end
  end

  assign borda = linha_ok & rx_ant & ~rx_sync;

  // ---------------- UART receiver ----------------
  uart_estado_t  u_st, u_prox;
  logic [CW-1:0] u_cnt;
  logic [2:0]    u_bit;
  logic [7:0]    u_dado;
  logic          fim_bit, fim_meio;
  logic          byte_valido, erro_uart;

  assign fim_bit     = (u_cnt == FIM_BIT);
  assign fim_meio    = (u_cnt == FIM_MEIO);
  assign byte_valido = (u_st == U_STOP) & fim_bit &  rx_sync;
  assign erro_uart   = (u_st == U_STOP) & fim_bit & ~rx_sync;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    u_prox = u_st;
    case (u_st)
      U_IDLE:  if (borda) u_prox = U_START;
      U_START: if (fim_meio) u_prox = rx_sync ? U_IDLE : U_DADOS;
      U_DADOS: if (fim_bit && u_bit == 3'd7) u_prox = U_STOP;
      U_STOP:  if (fim_bit) u_prox = U_IDLE;
      default: u_prox = U_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      u_st   <= U_IDLE;
      u_cnt  <= '0;
      u_bit  <= '0;
      u_dado <= '0;
    end else begin
      u_st <= u_prox;
      case (u_st)
        U_START: u_cnt <= fim_meio ? '0 : u_cnt + 1'b1;
        U_DADOS: begin
          if (fim_bit) begin
            u_cnt  <= '0;
            u_dado <= {rx_sync, u_dado[7:1]};
            u_bit  <= u_bit + 3'd1;
          end else begin
            u_cnt <= u_cnt + 1'b1;
          end
        end
        U_STOP:  u_cnt <= fim_bit ? '0 : u_cnt + 1'b1;
        default: begin
          u_cnt <= '0;
          u_bit <= '0;
        end
      endcase
    end
  end

  // ---------------- frame parser ----------------
  quadro_estado_t q_st, q_prox;
  logic [2:0]     q_idx;
  logic [2:0]     idx_esc;
  logic [3:0]     digitos [8];
  logic           eh_digito;
  logic           erro_quadro;

  assign eh_digito = (u_dado >= 8'h30) && (u_dado <= 8'h39);
  assign idx_esc   = (q_st == ESPERA) ? 3'd0 : q_idx;

  always_comb begin
    q_prox      = q_st;
    erro_quadro = 1'b0;
    pronto      = 1'b0;
    case (q_st)
      ESPERA: if (byte_valido && eh_digito) q_prox = DIGITO;
      DIGITO: begin
        if (erro_uart) begin
          q_prox = ESPERA;
        end else if (byte_valido) begin
          if (!eh_digito) begin
            erro_quadro = 1'b1;
            q_prox      = ESPERA;
          end else if (q_idx == 3'd7) begin
            q_prox = FINAL;
          end
        end
      end
      FINAL: begin
        if (erro_uart) begin
          q_prox = ESPERA;
        end else if (byte_valido) begin
          if (u_dado == TERMINADOR) begin
            q_prox = CONVERTE;
          end else begin
            erro_quadro = 1'b1;
            q_prox      = ESPERA;
          end
        end
      end
      CONVERTE: q_prox = PUBLICA;
      PUBLICA: begin
        pronto = 1'b1;
        q_prox = ESPERA;
      end
      default: q_prox = ESPERA;
    endcase
  end

  assign erro      = erro_uart | erro_quadro;
  assign db_estado = q_st;

  // Both words are written on the CONVERTE->PUBLICA edge, so they change together
  // and are already valid in the cycle pronto is high.
  // NOTE: the digit registers are a tiny array and must be cleared on reset, so they sit in the reset branch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_st        <= ESPERA;
      q_idx       <= '0;
      temperatura <= '0;
      umidade     <= '0;
      for (int i = 0; i < 8; i++) digitos[i] <= '0;
    end else begin
      q_st <= q_prox;
      if (q_prox == ESPERA) q_idx <= '0;
      if (byte_valido && eh_digito && (q_st == ESPERA || q_st == DIGITO)) begin
        digitos[idx_esc] <= u_dado[3:0];
        q_idx            <= idx_esc + 3'd1;
      end
      if (q_st == CONVERTE) begin
        temperatura <= {1'b0, bcd_bin(digitos[0], digitos[1]), 1'b0, bcd_bin(digitos[2], digitos[3])};
        umidade     <= {1'b0, bcd_bin(digitos[4], digitos[5]), 1'b0, bcd_bin(digitos[6], digitos[7])};
      end
    end
  end

endmodule

// File: tb/tb_recepcao_medida_uc_fd.sv
// Scoreboard bench for recepcao_medida_uc_fd: a frame-level model predicts pronto/erro
// events and published words; a monitor compares them as the DUT produces them.
module tb_recepcao_medida_uc_fd;

  localparam int CPB = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_serial = 1'b1;
  logic [15:0] temperatura, umidade;
  logic        pronto, erro;
  logic [2:0]  db_estado;

  recepcao_medida_uc_fd #(.CLKS_PER_BIT(CPB), .TERMINADOR(8'h23)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .temperatura (temperatura),
    .umidade     (umidade),
    .pronto      (pronto),
    .erro        (erro),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_erro;
    logic [15:0] t;
    logic [15:0] u;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] buf_q[$];
  logic [15:0] m_t = '0;
  logic [15:0] m_u = '0;
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  function automatic int dval(input logic [7:0] c);
    return int'(c) - 48;
  endfunction

  task automatic push_erro();
    ev_t e;
    e.is_erro = 1'b1; e.t = '0; e.u = '0;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input logic stop_ok);
    bit dig;
    ev_t e;
    int ti, td, ui, ud;
    dig = (b >= 8'h30) && (b <= 8'h39);
    if (!stop_ok) begin
      push_erro();
      buf_q.delete();
    end else if (buf_q.size() == 8) begin
      if (b == 8'h23) begin
        ti = dval(buf_q[0]) * 10 + dval(buf_q[1]);
        td = dval(buf_q[2]) * 10 + dval(buf_q[3]);
        ui = dval(buf_q[4]) * 10 + dval(buf_q[5]);
        ud = dval(buf_q[6]) * 10 + dval(buf_q[7]);
        m_t = 16'((ti << 8) | td);
        m_u = 16'((ui << 8) | ud);
        e.is_erro = 1'b0; e.t = m_t; e.u = m_u;
        exp_q.push_back(e);
      end else begin
        push_erro();
      end
      buf_q.delete();
    end else if (buf_q.size() == 0) begin
      if (dig) buf_q.push_back(b);
    end else if (dig) begin
      buf_q.push_back(b);
    end else begin
      push_erro();
      buf_q.delete();
    end
  endtask

  task automatic model_reset();
    buf_q.delete();
    exp_q.delete();
    m_t = '0;
    m_u = '0;
  endtask

  // ---------------- line driver ----------------
  task automatic bit_time(input logic v);
    rx_serial = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int bits);
    rx_serial = 1'b1;
    repeat (bits * CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    model_byte(b, stop_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_bit);
    if (!stop_bit) bit_time(1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_temp"}, 32'(temperatura), 32'(m_t));
    check({tag, "_umid"}, 32'(umidade), 32'(m_u));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset && (pronto || erro)) begin
      ev_t ev;
      check("pronto_erro_excl", 32'(pronto & erro), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_event: got pronto=%0b erro=%0b expected none (t=%0t)", pronto, erro, $time);
      end else begin
        ev = exp_q.pop_front();
        check("evt_is_erro", 32'(erro), 32'(ev.is_erro));
        if (!ev.is_erro) begin
          check("pub_temp", 32'(temperatura), 32'(ev.t));
          check("pub_umid", 32'(umidade), 32'(ev.u));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] frame [8];
    logic [7:0] bad;
    logic [7:0] b5;
    logic [7:0] ruido [5];
    int modo, pos;

    ruido[0] = 8'h41; ruido[1] = 8'h20; ruido[2] = 8'h23; ruido[3] = 8'h2F; ruido[4] = 8'h3A;

    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_temp", 32'(temperatura), 32'h0);
    check("rst_umid", 32'(umidade), 32'h0);
    check("rst_pronto", 32'(pronto), 32'h0);
    check("rst_erro", 32'(erro), 32'h0);
    check("rst_estado", 32'(db_estado), 32'h0);
    reset = 1'b1;
    idle(12);

    // Basic decode and range extremes.
    send_str("23506107#");
    idle(2);
    check("f1_temp", 32'(temperatura), 32'h1732);
    check("f1_umid", 32'(umidade), 32'h3D07);
    send_str("99999999#");
    idle(2);
    check_hold("f99");
    send_str("00000000#");
    idle(2);
    check_hold("f00");

    // Non-digit mid-frame.
    send_str("12345678#");
    send_str("2350A");
    idle(2);
    check_hold("after_A");
    send_str("11223344#");
    idle(2);
    check_hold("after_A_ok");

    // Framing error inside a frame, then a short glitch on the idle line.
    send_str("1234");
    send_byte(8'h35, 1'b0);
    send_str("678#");
    idle(2);
    check_hold("framing");
    rx_serial = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    idle(4);
    send_str("45671289#");
    idle(2);
    check_hold("glitch");

    // Leading noise in ESPERA, then a bad terminator.
    send_str("xy#");
    send_str("08150942#");
    idle(2);
    check_hold("noise");
    send_str("123456785");
    idle(2);
    check_hold("bad_term");

    // Reset during the data bits of the 5th digit, line left mid-byte.
    send_str("2350");
    b5 = 8'h36;
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(b5[i]);
    reset = 1'b0;
    model_reset();
    rx_serial = b5[3];
    repeat (2) @(posedge clock);
    #1;
    check("midrst_temp", 32'(temperatura), 32'h0);
    check("midrst_umid", 32'(umidade), 32'h0);
    check("midrst_estado", 32'(db_estado), 32'h0);
    repeat (CPB - 2) @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 4; i < 8; i++) bit_time(b5[i]);
    bit_time(1'b1);
    idle(12);
    check_hold("post_rst_idle");
    send_str("31415926#");
    idle(2);
    check_hold("post_rst");

    // Randomized frames with random corruptions.
    for (int it = 0; it < 12; it++) begin
      modo = $urandom_range(0, 5);
      pos  = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++) frame[i] = 8'(8'h30 + $urandom_range(0, 9));
      for (int i = 0; i < 8; i++) begin
        if (modo == 3 && i == pos) begin
          bad = ruido[$urandom_range(0, 4)];
          send_byte(bad, 1'b1);
        end else begin
          send_byte(frame[i], !(modo == 5 && i == pos));
        end
      end
      if (modo == 4) send_byte(8'(8'h30 + $urandom_range(0, 9)), 1'b1);
      else           send_byte(8'h23, 1'b1);
      idle(2);
      check_hold("rand");
    end

    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/recepcao_medida_uc_fd.md
Name: recepcao_medida_uc_fd

Overview:
- Receive end of the measurement serial link: deserializes UART 8N1 ASCII digits on rx_serial and decodes them back into binary measurement words.
- Reassembles the temperature and humidity words in the same field layout the measurement transmitter encodes.
- Sits on the monitoring side of the link and feeds the display/logging logic.
- Contains its own UART receiver, frame-parsing state machine and two-digit BCD-to-binary conversion.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be >= 4.
- TERMINADOR, 8'h23, ASCII byte that closes a frame ('#').

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_serial  in  1  UART line, idle high.
- temperatura  out  16  [14:8] integer part, [6:0] decimal part, bits 15 and 7 always 0.
- umidade  out  16  same layout as temperatura.
- pronto  out  1  one-cycle pulse when temperatura/umidade update.
- erro  out  1  one-cycle pulse on a rejected byte or frame.
- db_estado  out  3  current frame FSM state code, for debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - temperatura, umidade = 16'h0000; pronto = 0; erro = 0.
  - UART receiver goes to idle; frame FSM goes to ESPERA (code 0); all digit registers cleared.
- Input sync: rx_serial passes through 2 flops before use; the synchronizer flops reset to 1.
- UART receiver states: IDLE, START, DADOS, STOP.
  - IDLE -> START on a synchronized 1->0 edge.
  - START: wait CLKS_PER_BIT/2 cycles (integer division) and sample. If the line is high, treat as a glitch: back to IDLE, no byte, no erro.
  - DADOS: sample 8 bits LSB first, each CLKS_PER_BIT cycles after the previous sample.
  - STOP: sample CLKS_PER_BIT later.
    - Stop bit = 1: raise internal byte_valido for 1 cycle with the byte.
    - Stop bit = 0: framing error, pulse erro, byte discarded.
  - Then return to IDLE. A new start edge is accepted from the cycle after the stop sample.
- Frame format: 8 ASCII digits then TERMINADOR, in this order:
  - temp integer tens, temp integer units
  - temp decimal tens, temp decimal units
  - humidity integer tens, humidity integer units
  - humidity decimal tens, humidity decimal units
- Frame FSM states: ESPERA=0, DIGITO=1, FINAL=2, CONVERTE=3, PUBLICA=4.
  - ESPERA: digit byte (8'h30..8'h39) -> store as digit 0, index=1, go to DIGITO. Any other byte is ignored silently.
  - DIGITO: digit byte -> store at index, index++. When index reaches 8, go to FINAL.
  - DIGITO: non-digit byte (including TERMINADOR) -> pulse erro, clear index, go to ESPERA.
  - FINAL: TERMINADOR -> CONVERTE. Any other byte -> pulse erro, go to ESPERA.
  - CONVERTE (1 cycle): each field = tens*10 + units, computed from the low nibbles. Range 0..99, fits 7 bits.
  - PUBLICA (1 cycle): load both outputs atomically, pulse pronto, go to ESPERA.
- Latency: pronto is high exactly 2 cycles after the cycle in which the terminator's stop bit is sampled.
- Outputs hold their last valid frame until the next valid frame or reset. A rejected frame never alters them.
- pronto and erro are never high in the same cycle.
- Bytes arriving while in CONVERTE/PUBLICA cannot be lost: the minimum byte spacing (10 bit times) far exceeds 2 cycles.
- Reset asserted mid-byte or mid-frame: immediate abort to reset values. After release, reception resumes only at a fresh start edge; a partial byte in flight is ignored until the line is idle high.

Test Plan (CLKS_PER_BIT=8):
- Reset, then send "2350" "6107" "#" -> one pronto pulse; temperatura=16'h1732 (23, 50); umidade=16'h3D07 (61, 7); erro never high.
- Valid frame, then "99999999#" -> temperatura=16'h6363, umidade=16'h6363; then "00000000#" -> both outputs 16'h0000, pronto pulsed each time.
- "2350A" mid-frame -> erro pulse at 'A'; outputs unchanged; next full valid frame still decoded correctly.
- Byte sent with stop bit=0 within a frame -> erro pulse, frame discarded. Also a 2-cycle low glitch on idle line -> no byte, no erro.
- Bytes "xy#" in ESPERA, then a valid frame -> no erro from the leading bytes; correct decode. "12345678" followed by '5' instead of '#' -> erro, no pronto.
- Reset pulled low during the 5th digit's data bits, released, then a full frame -> outputs 0 during reset; the new frame decodes correctly with a single pronto.
